// File: rtl/comm_link_tx_scheduler.sv
// rtl/comm_link_tx_scheduler.sv - credit-gated round-robin transmit scheduler
// Arbitrates core-side valid/yumi sources and splits each word into two link beats, low half first.
module comm_link_tx_scheduler #(
   parameter int NUM_SRC    = 4,
   parameter int DATA_W     = 64,
   parameter int CREDIT_MAX = 16,
   parameter int TOKEN_DIV  = 8
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic [NUM_SRC-1:0]                  src_valid_i,
   input  logic [NUM_SRC*DATA_W-1:0]           src_data_i,
   output logic [NUM_SRC-1:0]                  src_yumi_o,
   output logic                                link_valid_o,
   output logic [DATA_W/2-1:0]                 link_data_o,
   output logic                                link_last_o,
   input  logic                                link_ready_i,
   input  logic                                token_i,
   output logic [$clog2(CREDIT_MAX+1)-1:0]     credit_o,
   output logic [$clog2(NUM_SRC)-1:0]          grant_id_o,
   output logic                                busy_o,
   output logic                                err_o
);
   localparam int CW = $clog2(CREDIT_MAX+1);
   localparam int IW = $clog2(NUM_SRC);
   localparam int HW = DATA_W/2;

   typedef enum logic [1:0] {S_IDLE, S_SEND_LO, S_SEND_HI} state_e;

   state_e              state_q, state_d;
   logic [DATA_W-1:0]   word_q, word_d;
   logic [IW-1:0]       grant_q, grant_d;
   logic [IW-1:0]       ptr_q, ptr_d;
   logic [CW-1:0]       credit_q, credit_d;
   logic                err_q, err_d;

   logic                can_issue;
   logic                capture;
   logic                win_found;
   logic [IW-1:0]       win_idx;
   logic [IW-1:0]       cand;
   logic [CW:0]         credit_sum;

   // Rotating priority: the first valid source at or after the pointer wins.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         cand = IW'((int'(ptr_q) + i) % NUM_SRC);
         if (!win_found && src_valid_i[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   // Registered credit only, so a token never unlocks a grant in its own cycle.
   assign can_issue = win_found && (credit_q != '0);

   always_comb begin
      state_d      = state_q;
      capture      = 1'b0;
      link_valid_o = 1'b0;
      link_last_o  = 1'b0;
      link_data_o  = '0;
      unique case (state_q)
         S_IDLE: begin
            if (can_issue) begin
               capture = 1'b1;
               state_d = S_SEND_LO;
            end
         end
         S_SEND_LO: begin
            link_valid_o = 1'b1;
            link_data_o  = word_q[HW-1:0];
            if (link_ready_i) state_d = S_SEND_HI;
         end
         S_SEND_HI: begin
            link_valid_o = 1'b1;
            link_last_o  = 1'b1;
            link_data_o  = word_q[DATA_W-1:HW];
            if (link_ready_i) begin
               if (can_issue) begin
                  capture = 1'b1;
                  state_d = S_SEND_LO;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      src_yumi_o = '0;
      word_d     = word_q;
      grant_d    = grant_q;
      ptr_d      = ptr_q;
      if (capture) begin
         src_yumi_o[win_idx] = 1'b1;
         word_d  = src_data_i[int'(win_idx)*DATA_W +: DATA_W];
         grant_d = win_idx;
         ptr_d   = (win_idx == IW'(NUM_SRC-1)) ? '0 : win_idx + IW'(1);
      end
   end

   // Token return and capture are netted before the saturation test.
   always_comb begin
      credit_sum = {1'b0, credit_q};
      if (token_i) credit_sum = credit_sum + (CW+1)'(TOKEN_DIV);
      if (capture) credit_sum = credit_sum - (CW+1)'(1);
      err_d = err_q;
      if (credit_sum > (CW+1)'(CREDIT_MAX)) begin
         credit_d = CW'(CREDIT_MAX);
         err_d    = 1'b1;
      end else begin
         credit_d = credit_sum[CW-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         word_q   <= '0;
         grant_q  <= '0;
         ptr_q    <= '0;
         credit_q <= CW'(CREDIT_MAX);
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         word_q   <= word_d;
         grant_q  <= grant_d;
         ptr_q    <= ptr_d;
         credit_q <= credit_d;
         err_q    <= err_d;
      end
   end

   assign credit_o   = credit_q;
   assign grant_id_o = grant_q;
   assign busy_o     = (state_q != S_IDLE);
   assign err_o      = err_q;
endmodule

// File: doc/comm_link_tx_scheduler.md
Name: comm_link_tx_scheduler

Overview:
Credit-gated transmit scheduler in front of the upstream comm-link PISO/SSO datapath. It round-robin arbitrates NUM_SRC core-side valid/yumi requesters and serializes each granted DATA_W word into two DATA_W/2 link beats (low half first). It spends one credit per word and replenishes credits from decimated return tokens, so the link never overruns the downstream receive FIFO.

Parameters:
NUM_SRC, 4, number of core-side requesters (>=2)
DATA_W, 64, core word width (even)
CREDIT_MAX, 16, receive-FIFO depth in words; also the reset credit value (multiple of TOKEN_DIV)
TOKEN_DIV, 8, words returned per token pulse (credit decimation)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
src_valid_i  in  NUM_SRC  per-source word valid
src_data_i  in  NUM_SRC*DATA_W  per-source word; source k occupies bits [k*DATA_W +: DATA_W]
src_yumi_o  out  NUM_SRC  one-hot dequeue strobe to the granted source
link_valid_o  out  1  beat valid to the PISO
link_data_o  out  DATA_W/2  beat data
link_last_o  out  1  high on the second (high-half) beat
link_ready_i  in  1  PISO accepts the beat when valid & ready
token_i  in  1  single-cycle token pulse, already synchronized to clk
credit_o  out  $clog2(CREDIT_MAX+1)  current available credits
grant_id_o  out  $clog2(NUM_SRC)  source of the word in flight
busy_o  out  1  high in SEND_LO or SEND_HI
err_o  out  1  sticky credit-overflow flag

Behaviour:
- Reset: state IDLE, credit_o=CREDIT_MAX, RR pointer=0, grant_id_o=0, err_o=0. Outputs src_yumi_o, link_valid_o, link_last_o and busy_o are 0; link_data_o=0. rst mid-word abandons the word; no yumi, beat or credit is replayed.
- States: IDLE, SEND_LO, SEND_HI.
- Capture condition: "can_issue" = (any src_valid_i) & (credit_o>0).
- Arbitration: round-robin. Search begins at the RR pointer, and the first valid source wins. Once a word is captured, the pointer moves to winner+1, wrapping NUM_SRC-1 -> 0.
- Capture cycle: src_yumi_o[winner]=1 (combinational, same cycle). The word is registered, grant_id_o <= winner, credit decrements by 1, and the next state is SEND_LO.
- IDLE: captures when can_issue holds; otherwise it stays in IDLE.
- SEND_LO: link_valid_o=1, link_data_o=word[DATA_W/2-1:0], link_last_o=0. On ready the next state is SEND_HI; otherwise the beat is held stable.
- SEND_HI: link_valid_o=1, link_data_o=word[DATA_W-1:DATA_W/2], link_last_o=1.
  - On ready with can_issue true: capture in the same cycle (back-to-back) and go to SEND_LO.
  - On ready with can_issue false: go to IDLE.
  - Without ready: hold.
- Latency: yumi in cycle N; the first beat is valid in cycle N+1; with ready always 1, the last beat is in N+2. Sustained throughput is 1 word per 2 cycles.
- Credits: next = credit + (token_i ? TOKEN_DIV : 0) - (capture ? 1 : 0), computed in one step (simultaneous token and capture are netted).
  - A token never enables a capture in its own cycle: can_issue uses the registered credit_o.
  - If next > CREDIT_MAX: saturate at CREDIT_MAX and set err_o=1. err_o is cleared only by rst.
- credit_o=0 blocks grants. An in-flight word still completes.
- src_yumi_o is never asserted for a source whose src_valid_i is 0. At most one bit is set at a time.

Test Plan:
- Single word: after reset, src_valid_i=0001 with data 0x1122334455667788, ready=1 -> yumi[0] in cycle 1; beats 0x55667788 (last=0) then 0x11223344 (last=1); credit_o 16->15.
- Round-robin fairness: all four sources valid continuously, tokens supplied, ready=1 -> grants 0,1,2,3,0,..., one word per 2 cycles, no idle cycle between words.
- Credit exhaustion: no tokens, source 2 always valid -> exactly 16 words sent; then credit_o=0, link_valid_o=0, yumi quiet. One token_i pulse -> credit_o=8 and sending resumes the following cycle.
- Backpressure: ready=0 for 5 cycles during SEND_LO and SEND_HI -> link_data_o and link_last_o stable, no new yumi; completion once ready=1.
- Simultaneous token and capture at credit_o=3 -> credit_o=10. A token at credit_o=12 -> credit_o=16 and err_o=1, and err_o stays 1.
- Reset mid-SEND_HI -> next cycle link_valid_o=0, credit_o=16, grant pointer 0, err_o=0.
